cache_stat_frame_packer: RTL and testbench

//  Counts cache-hierarchy events (L1I/L1D/L2 read, write, miss strobes), one counter per event.
//  On the rising edge of cpu_done it freezes the counters and serializes them into a byte frame.
//  It sits directly upstream of the UART byte transmitter and feeds it over a valid/ready

---
 rtl/cache_stat_frame_packer.sv | 178 +++++++++++++++++
 tb/tb_cache_stat_frame_packer.sv | 393 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_stat_frame_packer.sv
// Cache event counters frozen on cpu_done and streamed as a checksummed byte frame.
// Optional STAT_CYCLE_CNT_EN appends a saturating idle-cycle counter to the frame.
module cache_stat_frame_packer #(
    parameter int         NUM_EVT  = 8,
    parameter int         CNT_W    = 32,
    parameter logic [7:0] HDR_BYTE = 8'hA5
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic [NUM_EVT-1:0] evt_i,
    input  logic               cpu_done,
    output logic [7:0]         byte_data,
    output logic               byte_valid,
    input  logic               byte_ready,
    output logic               busy,
    output logic               frame_done
);
    localparam int BPC = CNT_W / 8;
`ifdef STAT_CYCLE_CNT_EN
    localparam int NCNT = NUM_EVT + 1;
`else
    localparam int NCNT = NUM_EVT;
`endif
    localparam int NB    = NCNT * BPC;
    localparam int FLEN  = NB + 2;
    localparam int IDX_W = $clog2(FLEN);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_HDR  = 3'd1;
    localparam logic [2:0] S_DATA = 3'd2;
    localparam logic [2:0] S_CKS  = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q [NCNT];
    logic [CNT_W-1:0] cnt_d [NCNT];
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [7:0]       data_q, data_d;
    logic [7:0]       cks_q, cks_d;
    logic             valid_q, valid_d;
    logic             fdone_q, fdone_d;
    logic             cpu_done_q, cpu_done_d;
    logic             armed_q, armed_d;

    logic [NCNT-1:0]  inc;
    logic [NB*8-1:0]  frame_vec;
    logic [IDX_W-1:0] sel;
    logic [7:0]       sel_byte;
    logic             edge_w;
    logic             xfer;

    // The cycle counter is simply an extra counter whose strobe is always high.
`ifdef STAT_CYCLE_CNT_EN
    assign inc = {1'b1, evt_i};
`else
    assign inc = evt_i;
`endif

    // Edges are only honoured once cpu_done has been seen low after reset.
    assign edge_w = cpu_done & ~cpu_done_q & armed_q;
    assign xfer   = valid_q & byte_ready;

    always_comb begin
        frame_vec = '0;
        for (int k = 0; k < NCNT; k++) begin
            frame_vec[(NCNT-1-k)*CNT_W +: CNT_W] = cnt_q[k];
        end
    end

    always_comb begin
        sel      = (state_q == S_HDR) ? '0 : idx_q + IDX_W'(1);
        sel_byte = '0;
        for (int j = 0; j < NB; j++) begin
            if (sel == IDX_W'(j)) begin
                sel_byte = frame_vec[(NB-1-j)*8 +: 8];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        data_d     = data_q;
        cks_d      = cks_q;
        valid_d    = valid_q;
        fdone_d    = 1'b0;
        cpu_done_d = cpu_done;
        armed_d    = armed_q | ~cpu_done;
        unique case (state_q)
            S_IDLE: begin
                for (int k = 0; k < NCNT; k++) begin
                    if (inc[k] && (cnt_q[k] != '1)) begin
                        cnt_d[k] = cnt_q[k] + CNT_W'(1);
                    end
                end
                if (edge_w) begin
                    state_d = S_HDR;
                    valid_d = 1'b1;
                    data_d  = HDR_BYTE;
                    cks_d   = '0;
                    idx_d   = '0;
                end
            end
            S_HDR: begin
                if (xfer) begin
                    cks_d   = cks_q ^ data_q;
                    data_d  = sel_byte;
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (xfer) begin
                    cks_d = cks_q ^ data_q;
                    if (idx_q == IDX_W'(NB - 1)) begin
                        state_d = S_CKS;
                        data_d  = cks_q ^ data_q;
                        idx_d   = '0;
                    end else begin
                        idx_d  = idx_q + IDX_W'(1);
                        data_d = sel_byte;
                    end
                end
            end
            S_CKS: begin
                if (xfer) begin
                    state_d = S_DONE;
                    valid_d = 1'b0;
                    data_d  = '0;
                    fdone_d = 1'b1;
                end
            end
            S_DONE: begin
                if (!cpu_done) begin
                    state_d = S_IDLE;
                    for (int k = 0; k < NCNT; k++) begin
                        cnt_d[k] = '0;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            data_q     <= '0;
            cks_q      <= '0;
            valid_q    <= 1'b0;
            fdone_q    <= 1'b0;
            cpu_done_q <= 1'b0;
            armed_q    <= 1'b0;
            for (int k = 0; k < NCNT; k++) begin
                cnt_q[k] <= '0;
            end
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            data_q     <= data_d;
            cks_q      <= cks_d;
            valid_q    <= valid_d;
            fdone_q    <= fdone_d;
            cpu_done_q <= cpu_done_d;
            armed_q    <= armed_d;
            for (int k = 0; k < NCNT; k++) begin
                cnt_q[k] <= cnt_d[k];
            end
        end
    end

    assign byte_data  = data_q;
    assign byte_valid = valid_q;
    assign frame_done = fdone_q;
    assign busy       = (state_q == S_HDR) || (state_q == S_DATA) || (state_q == S_CKS);

endmodule

// File: tb/tb_cache_stat_frame_packer.sv
// Randomized bench for cache_stat_frame_packer against a counting/frame model.
// Covers the 32-bit default instance plus an 8-bit instance for saturation.
module tb_cache_stat_frame_packer;
    localparam int NE = 8;
`ifdef STAT_CYCLE_CNT_EN
    localparam int NC = NE + 1;
`else
    localparam int NC = NE;
`endif
    localparam int FLEN  = NC * 4 + 2;
    localparam int FLEN8 = NC + 2;

    logic       clk = 1'b0;
    logic       rstn;
    logic [7:0] evt_i;
    logic       cpu_done;
    logic [7:0] byte_data;
    logic       byte_valid;
    logic       byte_ready;
    logic       busy;
    logic       frame_done;

    logic [7:0] evt8;
    logic       cpu_done8;
    logic [7:0] byte_data8;
    logic       byte_valid8;
    logic       byte_ready8;
    logic       busy8;
    logic       frame_done8;

    int checks = 0;
    int failures = 0;

    logic [31:0] mcnt [NE];
    logic [31:0] mcyc;
    bit          m_idle;
    logic [7:0]  m8cnt [NE];
    logic [7:0]  m8cyc;
    bit          m8_idle;
    logic [7:0]  last_frame [$];
    int          last_cycles;

    cache_stat_frame_packer dut (
        .clk(clk), .rstn(rstn), .evt_i(evt_i), .cpu_done(cpu_done),
        .byte_data(byte_data), .byte_valid(byte_valid), .byte_ready(byte_ready),
        .busy(busy), .frame_done(frame_done)
    );

    cache_stat_frame_packer #(.CNT_W(8)) dut8 (
        .clk(clk), .rstn(rstn), .evt_i(evt8), .cpu_done(cpu_done8),
        .byte_data(byte_data8), .byte_valid(byte_valid8), .byte_ready(byte_ready8),
        .busy(busy8), .frame_done(frame_done8)
    );

    always #5 clk = ~clk;

    task automatic clear_main();
        for (int k = 0; k < NE; k++) mcnt[k] = '0;
        mcyc = '0;
    endtask

    task automatic clear8();
        for (int k = 0; k < NE; k++) m8cnt[k] = '0;
        m8cyc = '0;
    endtask

    task automatic step();
        @(posedge clk);
        if (rstn) begin
            if (m_idle) begin
                for (int k = 0; k < NE; k++)
                    if (evt_i[k] && mcnt[k] != 32'hFFFF_FFFF) mcnt[k] = mcnt[k] + 1;
                if (mcyc != 32'hFFFF_FFFF) mcyc = mcyc + 1;
            end
            if (m8_idle) begin
                for (int k = 0; k < NE; k++)
                    if (evt8[k] && m8cnt[k] != 8'hFF) m8cnt[k] = m8cnt[k] + 1;
                if (m8cyc != 8'hFF) m8cyc = m8cyc + 1;
            end
        end
        #1;
    endtask

    // mode 0: ready always high, 1: random ready and cpu_done wiggle, 2: stall at byte 7
    task automatic run_frame(input int mode, input logic [7:0] edge_evt);
        logic [7:0] exp [$];
        logic [7:0] cks;
        logic [7:0] cur;
        bit xfer, last, done;
        int stall;
        exp = {};
        exp.push_back(8'hA5);
        for (int k = 0; k < NE; k++)
            for (int b = 3; b >= 0; b--) exp.push_back(mcnt[k][b*8 +: 8]);
`ifdef STAT_CYCLE_CNT_EN
        for (int b = 3; b >= 0; b--) exp.push_back(mcyc[b*8 +: 8]);
`endif
        cpu_done = 1'b1;
        evt_i = edge_evt;
        step();
        m_idle = 1'b0;
        // The edge-cycle event counts, so rebuild the counter part of exp.
        exp = {};
        exp.push_back(8'hA5);
        for (int k = 0; k < NE; k++)
            for (int b = 3; b >= 0; b--) exp.push_back(mcnt[k][b*8 +: 8]);
`ifdef STAT_CYCLE_CNT_EN
        for (int b = 3; b >= 0; b--) exp.push_back(mcyc[b*8 +: 8]);
`endif
        cks = '0;
        foreach (exp[i]) cks = cks ^ exp[i];
        exp.push_back(cks);

        checks++;
        if (byte_valid !== 1'b1 || byte_data !== 8'hA5 || busy !== 1'b1) begin
            failures++;
            $display("FAIL hdr: valid=%b data=%h busy=%b, required 1 a5 1",
                     byte_valid, byte_data, busy);
        end
        last_frame = {};
        last_cycles = 0;
        done = 1'b0;
        stall = 0;
        while (!done && last_cycles < 400) begin
            case (mode)
                0: byte_ready = 1'b1;
                1: begin
                    byte_ready = 1'($urandom);
                    cpu_done = 1'($urandom);
                end
                default: begin
                    byte_ready = !(last_frame.size() == 7 && stall < 5);
                    if (!byte_ready) stall++;
                end
            endcase
            evt_i = 8'($urandom);
            cur = byte_data;
            xfer = byte_valid && byte_ready;
            if (xfer) last_frame.push_back(byte_data);
            last = xfer && (last_frame.size() == FLEN);
            step();
            last_cycles++;
            if (last) begin
                done = 1'b1;
                checks++;
                if (frame_done !== 1'b1 || byte_valid !== 1'b0 || busy !== 1'b0) begin
                    failures++;
                    $display("FAIL done_entry: fd=%b valid=%b busy=%b, required 1 0 0",
                             frame_done, byte_valid, busy);
                end
            end else begin
                checks++;
                if (byte_valid !== 1'b1 || busy !== 1'b1 || frame_done !== 1'b0 ||
                    (!xfer && byte_data !== cur)) begin
                    failures++;
                    $display("FAIL hold: valid=%b busy=%b fd=%b data=%h, required 1 1 0 %s",
                             byte_valid, busy, frame_done, byte_data,
                             xfer ? "next" : "unchanged");
                end
            end
        end
        checks++;
        if (!done) begin
            failures++;
            $display("FAIL frame_timeout: got %0d bytes, required %0d", last_frame.size(), FLEN);
        end
        checks++;
        if (last_frame.size() != FLEN) begin
            failures++;
            $display("FAIL frame_len: got %0d, required %0d", last_frame.size(), FLEN);
        end else begin
            for (int i = 0; i < FLEN; i++) begin
                checks++;
                if (last_frame[i] !== exp[i]) begin
                    failures++;
                    $display("FAIL byte[%0d]: got %h, required %h", i, last_frame[i], exp[i]);
                end
            end
        end
        if (mode == 0) begin
            checks++;
            if (last_cycles != FLEN) begin
                failures++;
                $display("FAIL back_to_back: took %0d cycles, required %0d", last_cycles, FLEN);
            end
        end
        cpu_done = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (frame_done !== 1'b0 || busy !== 1'b0 || byte_valid !== 1'b0) begin
                failures++;
                $display("FAIL done_hold: fd=%b busy=%b valid=%b, required 0 0 0",
                         frame_done, busy, byte_valid);
            end
        end
        cpu_done = 1'b0;
        step();
        clear_main();
        m_idle = 1'b1;
        evt_i = '0;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        evt_i = '0; cpu_done = 1'b0; byte_ready = 1'b0;
        evt8 = '0; cpu_done8 = 1'b0; byte_ready8 = 1'b0;
        m_idle = 1'b0; m8_idle = 1'b0;
        clear_main(); clear8();
        #3;
        checks++;
        if (byte_valid !== 1'b0 || busy !== 1'b0 || frame_done !== 1'b0 || byte_data !== 8'h00) begin
            failures++;
            $display("FAIL reset: valid=%b busy=%b fd=%b data=%h, required 0 0 0 00",
                     byte_valid, busy, frame_done, byte_data);
        end
        step(); step();
        rstn = 1'b1;
        m_idle = 1'b1; m8_idle = 1'b1;
    endtask

    task automatic test_single_event();
        logic [7:0] x;
        evt_i = 8'h01;
        repeat (10) step();
        run_frame(0, 8'h00);
        checks++;
        if (last_frame.size() == FLEN && last_frame[4] !== 8'h0A) begin
            failures++;
            $display("FAIL cnt0_lsb: got %h, required 0a", last_frame[4]);
        end
        x = '0;
        for (int i = 0; i < last_frame.size() - 1; i++) x = x ^ last_frame[i];
        checks++;
        if (last_frame.size() == FLEN && last_frame[FLEN-1] !== x) begin
            failures++;
            $display("FAIL checksum: got %h, required %h", last_frame[FLEN-1], x);
        end
    endtask

    task automatic test_edge_event();
        evt_i = '0;
        repeat (3) step();
        run_frame(0, 8'h02);
        checks++;
        if (last_frame.size() == FLEN && last_frame[8] !== 8'h01) begin
            failures++;
            $display("FAIL edge_evt: got %h, required 01", last_frame[8]);
        end
    endtask

    task automatic test_stall();
        repeat (12) begin
            evt_i = 8'($urandom);
            step();
        end
        run_frame(2, 8'($urandom));
    endtask

    task automatic test_random();
        for (int it = 0; it < 3; it++) begin
            repeat ($urandom_range(60, 5)) begin
                evt_i = 8'($urandom);
                step();
            end
            run_frame(1, 8'($urandom));
        end
    endtask

    task automatic test_back_to_back();
        run_frame(0, 8'($urandom));
        run_frame(0, 8'($urandom));
    endtask

    task automatic test_saturation();
        logic [7:0] exp [$];
        logic [7:0] got [$];
        logic [7:0] cks;
        int n;
        repeat (300) begin
            evt8 = 8'($urandom) | 8'h04;
            step();
        end
        cpu_done8 = 1'b1;
        evt8 = 8'($urandom);
        step();
        m8_idle = 1'b0;
        exp = {};
        exp.push_back(8'hA5);
        for (int k = 0; k < NE; k++) exp.push_back(m8cnt[k]);
`ifdef STAT_CYCLE_CNT_EN
        exp.push_back(m8cyc);
`endif
        cks = '0;
        foreach (exp[i]) cks = cks ^ exp[i];
        exp.push_back(cks);
        byte_ready8 = 1'b1;
        got = {};
        n = 0;
        while (frame_done8 !== 1'b1 && n < 40) begin
            if (byte_valid8) got.push_back(byte_data8);
            evt8 = 8'($urandom);
            step();
            n++;
        end
        checks++;
        if (got.size() != FLEN8) begin
            failures++;
            $display("FAIL sat_len: got %0d, required %0d", got.size(), FLEN8);
        end else begin
            checks++;
            if (got[3] !== 8'hFF) begin
                failures++;
                $display("FAIL sat_cnt2: got %h, required ff", got[3]);
            end
            for (int i = 0; i < FLEN8; i++) begin
                checks++;
                if (got[i] !== exp[i]) begin
                    failures++;
                    $display("FAIL sat_byte[%0d]: got %h, required %h", i, got[i], exp[i]);
                end
            end
        end
        byte_ready8 = 1'b0;
        cpu_done8 = 1'b0;
        evt8 = '0;
        step();
        clear8();
        m8_idle = 1'b1;
    endtask

    task automatic test_reset_abort();
        int n, guard;
        repeat (7) begin
            evt_i = 8'($urandom);
            step();
        end
        cpu_done = 1'b1;
        evt_i = 8'($urandom);
        step();
        m_idle = 1'b0;
        byte_ready = 1'b1;
        n = 0;
        guard = 0;
        while (n < 6 && guard < 50) begin
            if (byte_valid && byte_ready) n++;
            step();
            guard++;
        end
        #2 rstn = 1'b0;
        #1;
        checks++;
        if (byte_valid !== 1'b0 || busy !== 1'b0 || frame_done !== 1'b0) begin
            failures++;
            $display("FAIL abort: valid=%b busy=%b fd=%b, required 0 0 0",
                     byte_valid, busy, frame_done);
        end
        clear_main(); clear8();
        m_idle = 1'b0; m8_idle = 1'b0;
        byte_ready = 1'b0;
        step(); step();
        rstn = 1'b1;
        m_idle = 1'b1; m8_idle = 1'b1;
        for (int i = 0; i < 10; i++) begin
            evt_i = 8'($urandom);
            step();
            checks++;
            if (busy !== 1'b0 || byte_valid !== 1'b0) begin
                failures++;
                $display("FAIL no_restart[%0d]: busy=%b valid=%b, required 0 0",
                         i, busy, byte_valid);
            end
        end
        cpu_done = 1'b0;
        evt_i = 8'($urandom);
        step();
        run_frame(0, 8'($urandom));
    endtask

    initial begin
        test_reset();
        test_single_event();
        test_edge_event();
        test_stall();
        test_random();
        test_back_to_back();
        test_saturation();
        test_reset_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
